ddr3_top_ex_pattern_ctrl: RTL and testbench
===========================================

// Module: ddr3_top_ex_pattern_ctrl
// PURPOSE
//   Sequences an 8-bit LFSR pattern generator/checker for the DDR3 example driver.
//   Write pass: streams num_beats LFSR words to the write datapath.
//   Read pass: reloads the same seed, issues num_beats read commands and compares returned data to the regenerated sequence.
//   Reports pass/fail, error count and timeout to the example top-level status logic.
// PARAMETERS
//   CNT_W        16   width of the beat counters and of num_beats
//   ERR_W        8    width of err_count (saturating)
//   TIMEOUT      1024 max cycles in READ with no rd_valid before abort
//   DEFAULT_SEED 32   seed used when seed input is 0 (all-zero state locks up)
// PORTS
//   clk          in  1      single clock, all logic rising-edge
//   reset        in  1      synchronous, active-high
//   start        in  1      1-cycle pulse; begins a run when idle
//   seed         in  8      LFSR seed, sampled on accepted start
//   num_beats    in  CNT_W  beats per pass, sampled on accepted start
//   busy         out 1      high from accepted start until done
//   done         out 1      1-cycle pulse at end of run
//   pass         out 1      valid from done until next accepted start
//   timeout      out 1      run aborted by read timeout; held like pass
//   err_count    out ERR_W  mismatching read beats, saturates at all-ones
//   wr_valid     out 1      write beat valid
//   wr_data      out 8      write beat data
//   wr_ready     in  1      write beat accepted when wr_valid & wr_ready
//   rd_cmd_valid out 1      read command valid
//   rd_cmd_ready in  1      read command accepted when valid & ready
//   rd_valid     in  1      returned read beat, in command order
//   rd_data      in  8      returned read data
// BEHAVIOUR
//   Reset: state=IDLE; busy, done, pass, timeout, wr_valid, rd_cmd_valid = 0.
//     err_count = 0; internal LFSRs = DEFAULT_SEED; counters = 0.
//   LFSR step (polynomial x^8+x^4+x^3+x^2+1), from d to n:
//     n0=d7, n1=d0, n2=d1^d7, n3=d2^d7, n4=d3^d7, n5=d4, n6=d5, n7=d6.
//   Effective seed s = (seed==0) ? DEFAULT_SEED[7:0] : seed.
//   IDLE: start -> latch s and num_beats; clear err_count, pass, timeout; busy=1 next cycle.
//     num_beats==0 -> DONE directly. Otherwise wr_lfsr=s and go to WRITE.
//   WRITE: wr_valid=1, wr_data=wr_lfsr (registered output).
//     Each handshake advances wr_lfsr and increments wr_cnt.
//     wr_data holds stable while stalled.
//     Handshake with wr_cnt==num_beats-1 -> READ next cycle; wr_valid drops the same cycle.
//     On entering READ: exp_lfsr=s, cmd_cnt=0, rcv_cnt=0, idle_cnt=0.
//   READ: rd_cmd_valid=1 while cmd_cnt<num_beats; each handshake increments cmd_cnt.
//     Each rd_valid compares rd_data to exp_lfsr.
//       Mismatch -> err_count+1, saturating.
//       Then advance exp_lfsr and increment rcv_cnt.
//     idle_cnt clears on rd_valid and increments otherwise.
//       idle_cnt==TIMEOUT-1 with no rd_valid -> timeout=1 and DONE.
//     rd_valid with rcv_cnt==num_beats-1 -> DONE.
//     Command issue and data return overlap; rd_valid before the first command is still checked.
//   DONE (1 cycle): done=1, busy=0 in the next cycle.
//     pass = (err_count==0) & !timeout, including the final beat's compare.
//     Return to IDLE.
//   Boundaries:
//     start while busy is ignored.
//     rd_valid outside READ is ignored (no count change).
//     wr_ready/rd_cmd_ready with valid low has no effect.
//     reset mid-run: next cycle equals the reset state; no done pulse.
//     Counters wrap never: num_beats max 2^CNT_W-1 is legal.
// STRUCTURE
//   Package ddr3_top_ex_pattern_pkg:
//     state enum {IDLE, WRITE, READ, DONE}.
//     function lfsr8_next(d) implementing the step above.
//     LFSR_W=8 constant.
//   Sub-module ddr3_top_ex_pattern_chk:
//     exp_lfsr, compare, saturating err_count, idle/timeout counter.
//     Controlled by load/enable from the FSM.
//   FSM, wr_lfsr and cmd/wr counters stay in this module.
// TESTING
//   1. seed=0x20, num_beats=4, wr_ready=1, loopback memory model
//      -> wr_data 0x20,0x40,0x80,0x1D on consecutive cycles.
//      -> read beats match; done pulse, pass=1, err_count=0.
//   2. Same run with wr_ready low on cycles 2-3 of WRITE
//      -> wr_data holds 0x40 while stalled; sequence unchanged; pass=1.
//   3. Model returns 0x81 for beat 2 and 0x00 for beat 3
//      -> err_count=2, pass=0, done once.
//   4. Model drops all reads, TIMEOUT=16
//      -> done 16 cycles after last rd_valid opportunity; timeout=1, pass=0.
//   5. seed=0 -> first wr_data=0x20. num_beats=0 -> done one cycle after busy rises, pass=1.
//   6. reset asserted in WRITE beat 2 -> busy, wr_valid, err_count =0 next cycle.
//      start during busy is ignored.
//      A fresh start runs to pass=1.

Source files
------------

// File: rtl/ddr3_top_ex_pattern_pkg.sv
// Shared types and helpers for the DDR3 example LFSR pattern controller.
// Provides the controller state enum, the LFSR width and the LFSR step.
package ddr3_top_ex_pattern_pkg;

   localparam int LFSR_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      READ,
      DONE
   } state_e;

   // x^8+x^4+x^3+x^2+1 Galois step
   function automatic logic [LFSR_W-1:0] lfsr8_next(
      input logic [LFSR_W-1:0] d
   );
      logic [LFSR_W-1:0] n;
      n[0] = d[7];
      n[1] = d[0];
      n[2] = d[1] ^ d[7];
      n[3] = d[2] ^ d[7];
      n[4] = d[3] ^ d[7];
      n[5] = d[4];
      n[6] = d[5];
      n[7] = d[6];
      return n;
   endfunction

endpackage

// File: rtl/ddr3_top_ex_pattern_chk.sv
// Read-data checker: regenerates the expected LFSR stream, counts
// mismatches (saturating) and flags a read-return timeout.
// Ports: clk_i/reset_i; clr_i clears err_count; load_i reloads seed_i
// and the idle counter; en_i qualifies rd_valid_i/rd_data_i;
// err_count_o is the mismatch count; tmo_o fires on the last idle cycle.
module ddr3_top_ex_pattern_chk
   import ddr3_top_ex_pattern_pkg::*;
#(
   parameter int ERR_W        = 8,
   parameter int TIMEOUT      = 1024,
   parameter int DEFAULT_SEED = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              clr_i,
   input  logic              load_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic              en_i,
   input  logic              rd_valid_i,
   input  logic [LFSR_W-1:0] rd_data_i,
   output logic [ERR_W-1:0]  err_count_o,
   output logic              tmo_o
);

   localparam int IDLE_W = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT - 1);
   localparam logic [LFSR_W-1:0] DEF_S = LFSR_W'(DEFAULT_SEED);

   logic [LFSR_W-1:0] exp_q;
   logic [ERR_W-1:0]  err_q;
   logic [IDLE_W-1:0] idle_q;

   assign err_count_o = err_q;
   assign tmo_o = en_i & ~rd_valid_i & (idle_q == IDLE_LAST);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         exp_q  <= DEF_S;
         err_q  <= '0;
         idle_q <= '0;
      end else begin
         if (clr_i) begin
            err_q <= '0;
         end
         if (load_i) begin
            exp_q  <= seed_i;
            idle_q <= '0;
         end else if (en_i) begin
            if (rd_valid_i) begin
               if (rd_data_i != exp_q && err_q != '1) begin
                  err_q <= err_q + 1'b1;
               end
               exp_q  <= lfsr8_next(exp_q);
               idle_q <= '0;
            end else begin
               idle_q <= idle_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/ddr3_top_ex_pattern_ctrl.sv
// Sequencer for the DDR3 example LFSR write/read-back pattern test.
// Ports: start_i/seed_i/num_beats_i launch a run; busy_o/done_o/pass_o/
// timeout_o/err_count_o report status; wr_* is the write beat stream,
// rd_cmd_* issues read commands, rd_valid_i/rd_data_i return read data.
module ddr3_top_ex_pattern_ctrl
   import ddr3_top_ex_pattern_pkg::*;
#(
   parameter int CNT_W        = 16,
   parameter int ERR_W        = 8,
   parameter int TIMEOUT      = 1024,
   parameter int DEFAULT_SEED = 32
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              start_i,
   input  logic [LFSR_W-1:0] seed_i,
   input  logic [CNT_W-1:0]  num_beats_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              timeout_o,
   output logic [ERR_W-1:0]  err_count_o,
   output logic              wr_valid_o,
   output logic [LFSR_W-1:0] wr_data_o,
   input  logic              wr_ready_i,
   output logic              rd_cmd_valid_o,
   input  logic              rd_cmd_ready_i,
   input  logic              rd_valid_i,
   input  logic [LFSR_W-1:0] rd_data_i
);

   localparam logic [LFSR_W-1:0] DEF_S = LFSR_W'(DEFAULT_SEED);
   localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

   state_e            state_q;
   logic              busy_q, done_q, pass_q, timeout_q;
   logic              wr_valid_q, rd_cmd_valid_q;
   logic [LFSR_W-1:0] seed_q, wr_lfsr_q;
   logic [CNT_W-1:0]  nb_q, wr_cnt_q, cmd_cnt_q, rcv_cnt_q;

   logic [LFSR_W-1:0] seed_d;
   logic wr_hs, wr_last, cmd_hs, rd_last;
   logic chk_clr, chk_load, chk_en, chk_tmo;

   // all-zero seed would lock the LFSR
   assign seed_d   = (seed_i == '0) ? DEF_S : seed_i;
   assign wr_hs    = wr_valid_q & wr_ready_i;
   assign wr_last  = wr_hs & (wr_cnt_q == nb_q - ONE);
   assign cmd_hs   = rd_cmd_valid_q & rd_cmd_ready_i;
   assign rd_last  = rd_valid_i & (rcv_cnt_q == nb_q - ONE);
   assign chk_clr  = (state_q == IDLE) & start_i;
   assign chk_load = (state_q == WRITE) & wr_last;
   assign chk_en   = (state_q == READ);

   ddr3_top_ex_pattern_chk #(
      .ERR_W        (ERR_W),
      .TIMEOUT      (TIMEOUT),
      .DEFAULT_SEED (DEFAULT_SEED)
   ) u_chk (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .clr_i       (chk_clr),
      .load_i      (chk_load),
      .seed_i      (seed_q),
      .en_i        (chk_en),
      .rd_valid_i  (rd_valid_i),
      .rd_data_i   (rd_data_i),
      .err_count_o (err_count_o),
      .tmo_o       (chk_tmo)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q        <= IDLE;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         pass_q         <= 1'b0;
         timeout_q      <= 1'b0;
         wr_valid_q     <= 1'b0;
         rd_cmd_valid_q <= 1'b0;
         seed_q         <= DEF_S;
         wr_lfsr_q      <= DEF_S;
         nb_q           <= '0;
         wr_cnt_q       <= '0;
         cmd_cnt_q      <= '0;
         rcv_cnt_q      <= '0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  seed_q    <= seed_d;
                  nb_q      <= num_beats_i;
                  pass_q    <= 1'b0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b1;
                  wr_cnt_q  <= '0;
                  wr_lfsr_q <= seed_d;
                  if (num_beats_i == '0) begin
                     state_q <= DONE;
                  end else begin
                     state_q    <= WRITE;
                     wr_valid_q <= 1'b1;
                  end
               end
            end
            WRITE: begin
               if (wr_hs) begin
                  wr_lfsr_q <= lfsr8_next(wr_lfsr_q);
                  wr_cnt_q  <= wr_cnt_q + ONE;
               end
               if (wr_last) begin
                  state_q        <= READ;
                  wr_valid_q     <= 1'b0;
                  rd_cmd_valid_q <= 1'b1;
                  cmd_cnt_q      <= '0;
                  rcv_cnt_q      <= '0;
               end
            end
            READ: begin
               if (cmd_hs) begin
                  cmd_cnt_q      <= cmd_cnt_q + ONE;
                  rd_cmd_valid_q <= (cmd_cnt_q + ONE) < nb_q;
               end
               if (rd_valid_i) begin
                  rcv_cnt_q <= rcv_cnt_q + ONE;
               end
               if (chk_tmo | rd_last) begin
                  state_q        <= DONE;
                  rd_cmd_valid_q <= 1'b0;
                  timeout_q      <= chk_tmo;
               end
            end
            DONE: begin
               // err_count already holds the final beat's compare here
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               pass_q  <= (err_count_o == '0) & ~timeout_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign busy_o         = busy_q;
   assign done_o         = done_q;
   assign pass_o         = pass_q;
   assign timeout_o      = timeout_q;
   assign wr_valid_o     = wr_valid_q;
   assign wr_data_o      = wr_lfsr_q;
   assign rd_cmd_valid_o = rd_cmd_valid_q;

endmodule

// File: tb/tb_ddr3_top_ex_pattern_ctrl.sv
// Randomized bench for the LFSR pattern controller with a loopback
// memory model and a behavioural expected-stream reference.
module tb_ddr3_top_ex_pattern_ctrl;

   localparam int TMO = 16;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       start_i;
   logic [7:0] seed_i;
   logic [15:0] num_beats_i;
   logic       busy_o, done_o, pass_o, timeout_o;
   logic [7:0] err_count_o;
   logic       wr_valid_o;
   logic [7:0] wr_data_o;
   logic       wr_ready_i;
   logic       rd_cmd_valid_o;
   logic       rd_cmd_ready_i;
   logic       rd_valid_i;
   logic [7:0] rd_data_i;

   int errors = 0;
   int checks = 0;
   logic [7:0] mem [0:511];
   logic [7:0] wr_log[$];

   ddr3_top_ex_pattern_ctrl #(
      .CNT_W        (16),
      .ERR_W        (8),
      .TIMEOUT      (TMO),
      .DEFAULT_SEED (32)
   ) dut (
      .clk_i          (clk_i),
      .reset_i        (reset_i),
      .start_i        (start_i),
      .seed_i         (seed_i),
      .num_beats_i    (num_beats_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .pass_o         (pass_o),
      .timeout_o      (timeout_o),
      .err_count_o    (err_count_o),
      .wr_valid_o     (wr_valid_o),
      .wr_data_o      (wr_data_o),
      .wr_ready_i     (wr_ready_i),
      .rd_cmd_valid_o (rd_cmd_valid_o),
      .rd_cmd_ready_i (rd_cmd_ready_i),
      .rd_valid_i     (rd_valid_i),
      .rd_data_i      (rd_data_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] lfsr_ref(input logic [7:0] d);
      return {d[6:0], 1'b0} ^ (d[7] ? 8'h1D : 8'h00);
   endfunction

   // mode: 0 random, 1 ideal, 2 write stall, 3 corrupt, 4 drop, 5 all bad
   task automatic do_run(input logic [7:0] sd, input int nb,
                         input int mode);
      logic [7:0] s, v, dat;
      logic [7:0] exp_q[$];
      int pend[$];
      int wr_idx, cmd_idx, rcv, errs, cyc, last_wr, idx, wcyc, exp_err;
      bit done_seen;
      s = (sd == 8'h00) ? 8'h20 : sd;
      v = s;
      for (int i = 0; i < nb; i++) begin
         exp_q.push_back(v);
         v = lfsr_ref(v);
      end
      wr_log.delete();
      wr_idx = 0; cmd_idx = 0; rcv = 0; errs = 0;
      cyc = 0; last_wr = 0; wcyc = 0; done_seen = 0;
      start_i = 1'b1;
      seed_i = sd;
      num_beats_i = 16'(nb);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      check("busy_rise", {31'b0, busy_o}, 1);
      while (cyc < 4000) begin
         if (done_o) begin
            done_seen = 1;
            break;
         end
         start_i = (cyc == 2);
         seed_i = 8'hA5;
         num_beats_i = 16'd3;
         case (mode)
            0: wr_ready_i = ($urandom % 3) != 0;
            2: wr_ready_i = (wcyc != 1) && (wcyc != 2);
            default: wr_ready_i = 1'b1;
         endcase
         if (wr_valid_o) begin
            if (wr_idx < nb) check("wr_data", {24'b0, wr_data_o},
                                   {24'b0, exp_q[wr_idx]});
            else check("wr_extra", {31'b0, wr_valid_o}, 0);
            wcyc++;
            if (wr_ready_i) begin
               mem[wr_idx] = wr_data_o;
               wr_log.push_back(wr_data_o);
               wr_idx++;
               last_wr = cyc;
            end
         end
         rd_cmd_ready_i = (mode == 0) ? (($urandom % 8) != 0) : 1'b1;
         rd_valid_i = 1'b0;
         rd_data_i = 8'h00;
         if (pend.size() > 0 && mode != 4 &&
             (mode != 0 || ($urandom % 4) != 0)) begin
            idx = pend.pop_front();
            dat = mem[idx];
            if (mode == 3 && idx == 2) dat = 8'h81;
            if (mode == 3 && idx == 3) dat = 8'h00;
            if (mode == 5) dat = ~dat;
            rd_valid_i = 1'b1;
            rd_data_i = dat;
            if (dat != exp_q[idx]) errs++;
            rcv++;
         end else if (mode == 0 && wr_valid_o && ($urandom % 4) == 0) begin
            rd_valid_i = 1'b1;
            rd_data_i = 8'hFF;
         end
         if (rd_cmd_valid_o && rd_cmd_ready_i) begin
            pend.push_back(cmd_idx);
            cmd_idx++;
         end
         @(posedge clk_i); #1;
         cyc++;
      end
      start_i = 1'b0;
      wr_ready_i = 1'b0;
      rd_cmd_ready_i = 1'b0;
      rd_valid_i = 1'b0;
      exp_err = (errs > 255) ? 255 : errs;
      check("done_seen", {31'b0, done_seen}, 1);
      check("busy_fall", {31'b0, busy_o}, 0);
      check("wr_beats", wr_idx, nb);
      check("cmd_beats", cmd_idx, nb);
      if (mode != 4) check("rd_beats", rcv, nb);
      check("err_count", {24'b0, err_count_o}, exp_err);
      check("timeout", {31'b0, timeout_o}, (mode == 4) ? 1 : 0);
      check("pass", {31'b0, pass_o},
            (errs == 0 && mode != 4) ? 1 : 0);
      if (nb == 0) check("zero_lat", cyc, 1);
      if (mode == 4) check("tmo_lat", cyc - last_wr, TMO + 2);
      @(posedge clk_i); #1;
      check("done_pulse", {31'b0, done_o}, 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset_i = 1'b1;
      start_i = 1'b0;
      seed_i = 8'h00;
      num_beats_i = 16'd0;
      wr_ready_i = 1'b0;
      rd_cmd_ready_i = 1'b0;
      rd_valid_i = 1'b0;
      rd_data_i = 8'h00;
      repeat (3) @(posedge clk_i);
      #1 reset_i = 1'b0;
      check("rst_busy", {31'b0, busy_o}, 0);
      check("rst_done", {31'b0, done_o}, 0);
      check("rst_pass", {31'b0, pass_o}, 0);
      check("rst_tmo", {31'b0, timeout_o}, 0);
      check("rst_wrv", {31'b0, wr_valid_o}, 0);
      check("rst_cmdv", {31'b0, rd_cmd_valid_o}, 0);
      check("rst_err", {24'b0, err_count_o}, 0);

      do_run(8'h20, 4, 1);
      check("seq0", {24'b0, wr_log[0]}, 32'h20);
      check("seq1", {24'b0, wr_log[1]}, 32'h40);
      check("seq2", {24'b0, wr_log[2]}, 32'h80);
      check("seq3", {24'b0, wr_log[3]}, 32'h1D);

      do_run(8'h20, 4, 2);
      check("stall_seq1", {24'b0, wr_log[1]}, 32'h40);

      do_run(8'h20, 4, 3);
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      check("idle_rst_err", {24'b0, err_count_o}, 0);

      do_run(8'h20, 4, 4);

      do_run(8'h00, 5, 1);
      check("seed0_first", {24'b0, wr_log[0]}, 32'h20);
      do_run(8'h77, 0, 1);

      do_run(8'h3C, 260, 5);

      start_i = 1'b1;
      seed_i = 8'h33;
      num_beats_i = 16'd8;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      wr_ready_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check("mid_wr_data", {24'b0, wr_data_o},
            {24'b0, lfsr_ref(lfsr_ref(8'h33))});
      reset_i = 1'b1;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      wr_ready_i = 1'b0;
      check("mid_rst_busy", {31'b0, busy_o}, 0);
      check("mid_rst_wrv", {31'b0, wr_valid_o}, 0);
      check("mid_rst_err", {24'b0, err_count_o}, 0);
      check("mid_rst_cmdv", {31'b0, rd_cmd_valid_o}, 0);
      @(posedge clk_i); #1;
      check("mid_rst_nodone", {31'b0, done_o}, 0);
      do_run(8'h5A, 6, 1);

      for (int r = 0; r < 8; r++) begin
         do_run(8'($urandom), 1 + int'($urandom % 40), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
